// File: rtl/assert_event_arbiter.sv
// Round-robin arbiter that funnels assertion/cover/assume events from N_SRC sources
// into one registered report stream, keeps fail/cover statistics and emits a final summary.
module assert_event_arbiter #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           src_valid,
    output logic [N_SRC-1:0]           src_ready,
    input  logic [2*N_SRC-1:0]         src_kind,
    input  logic [ID_W*N_SRC-1:0]      src_id,
    output logic                       rpt_valid,
    input  logic                       rpt_ready,
    output logic [$clog2(N_SRC)-1:0]   rpt_src,
    output logic [1:0]                 rpt_kind,
    output logic [ID_W-1:0]            rpt_id,
    input  logic                       final_req,
    output logic                       final_done,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic [CNT_W-1:0]           cover_cnt
);

    localparam int SRC_W = $clog2(N_SRC);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_SUMMARY = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [SRC_W-1:0]     r_ptr;
    logic                 r_valid;
    logic [SRC_W-1:0]     r_src;
    logic [1:0]           r_kind;
    logic [ID_W-1:0]      r_id;
    logic [CNT_W-1:0]     r_fail;
    logic [CNT_W-1:0]     r_cover;
    logic                 r_done;

    logic                 w_can_accept;
    logic                 w_found;
    logic [SRC_W-1:0]     w_gidx;
    logic                 w_accept;
    logic [N_SRC-1:0]     w_grant;
    logic [1:0]           w_kind;
    logic [ID_W-1:0]      w_id;
    logic [SRC_W-1:0]     w_ptr_next;
    logic                 w_is_fail;
    logic                 w_is_cover;
    logic                 w_load_sum;
    logic                 w_handshake;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Clamp the fail count into the identifier field (all ones once it no longer fits).
    function automatic logic [ID_W-1:0] sum_id(input logic [CNT_W-1:0] c);
        logic [CNT_W+ID_W-1:0] v_wide;
        logic                  v_over;
        v_wide = {{ID_W{1'b0}}, c};
        v_over = |(v_wide >> ID_W);
        return v_over ? {ID_W{1'b1}} : v_wide[ID_W-1:0];
    endfunction

    // The register can take a new event when empty or being emptied; rst_n keeps src_ready low in reset.
    assign w_can_accept = rst_n && (r_state == ST_RUN) && (!r_valid || rpt_ready);
    assign w_handshake  = r_valid && rpt_ready;
    assign w_load_sum   = (r_state == ST_DRAIN) && !r_valid;

    // Round-robin search for the first valid source starting at r_ptr.
    always_comb begin : p_rr_search
        int   v_idx;
        logic v_hit;
        w_found = 1'b0;
        w_gidx  = '0;
        v_idx   = 0;
        v_hit   = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            v_idx = int'(r_ptr) + k;
            v_idx = (v_idx >= N_SRC) ? (v_idx - N_SRC) : v_idx;
            v_hit = !w_found && src_valid[v_idx];
            w_gidx  = v_hit ? SRC_W'(v_idx) : w_gidx;
            w_found = w_found | v_hit;
        end
    end

    assign w_accept   = w_found && w_can_accept;
    assign w_grant    = w_accept ? ({{(N_SRC-1){1'b0}}, 1'b1} << w_gidx) : {N_SRC{1'b0}};
    assign w_kind     = src_kind[int'(w_gidx)*2 +: 2];
    assign w_id       = src_id[int'(w_gidx)*ID_W +: ID_W];
    assign w_ptr_next = (w_gidx == SRC_W'(N_SRC-1)) ? {SRC_W{1'b0}} : w_gidx + {{(SRC_W-1){1'b0}}, 1'b1};
    assign w_is_fail  = (w_kind == 2'd0) || (w_kind == 2'd2);
    assign w_is_cover = (w_kind == 2'd1);

    // Phase sequencing: run, drain the output register, emit summary, then park.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (final_req) w_state_next = ST_DRAIN;
                else           w_state_next = ST_RUN;
            end
            ST_DRAIN: begin
                if (!r_valid) w_state_next = ST_SUMMARY;
                else          w_state_next = ST_DRAIN;
            end
            ST_SUMMARY: begin
                if (w_handshake) w_state_next = ST_DONE;
                else             w_state_next = ST_SUMMARY;
            end
            ST_DONE:  w_state_next = ST_DONE;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_ptr <= w_ptr_next;
            else          r_ptr <= r_ptr;
        end
    end

    // Output record register: new event, summary record, or release on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_src   <= '0;
            r_kind  <= 2'd0;
            r_id    <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_src   <= w_gidx;
            r_kind  <= w_kind;
            r_id    <= w_id;
        end else if (w_load_sum) begin
            r_valid <= 1'b1;
            r_src   <= '0;
            r_kind  <= 2'd3;
            r_id    <= sum_id(r_fail);
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Saturating statistics, updated in the acceptance cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail  <= '0;
            r_cover <= '0;
        end else begin
            if (w_accept && w_is_fail)  r_fail  <= sat_inc(r_fail);
            else                        r_fail  <= r_fail;
            if (w_accept && w_is_cover) r_cover <= sat_inc(r_cover);
            else                        r_cover <= r_cover;
        end
    end

    // Completion flag, sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else if ((r_state == ST_SUMMARY) && w_handshake) begin
            r_done <= 1'b1;
        end else begin
            r_done <= r_done;
        end
    end

    assign src_ready  = w_grant;
    assign rpt_valid  = r_valid;
    assign rpt_src    = r_src;
    assign rpt_kind   = r_kind;
    assign rpt_id     = r_id;
    assign final_done = r_done;
    assign fail_cnt   = r_fail;
    assign cover_cnt  = r_cover;

endmodule

// File: tb/tb_assert_event_arbiter.sv
// Randomized + directed bench for assert_event_arbiter; a default-size and a narrow
// (CNT_W=4, ID_W=3) instance share stimulus and are checked against one reference model.
module tb_assert_event_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 8;
    localparam int CW   = 16;
    localparam int SIDW = 3;
    localparam int SCW  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         src_valid;
    logic [2*N-1:0]       src_kind;
    logic [IDW*N-1:0]     src_id;
    logic [SIDW*N-1:0]    s_src_id;
    logic                 rpt_ready;
    logic                 final_req;

    logic [N-1:0]         m_ready,  s_ready;
    logic                 m_rvalid, s_rvalid;
    logic [1:0]           m_rsrc,   s_rsrc;
    logic [1:0]           m_rkind,  s_rkind;
    logic [IDW-1:0]       m_rid;
    logic [SIDW-1:0]      s_rid;
    logic                 m_done,   s_done;
    logic [CW-1:0]        m_fail,   m_cover;
    logic [SCW-1:0]       s_fail,   s_cover;

    always #5 clk = ~clk;

    always_comb begin
        s_src_id = '0;
        for (int i = 0; i < N; i++) s_src_id[SIDW*i +: SIDW] = src_id[IDW*i +: SIDW];
    end

    assert_event_arbiter #(.N_SRC(N), .ID_W(IDW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(m_ready),
        .src_kind(src_kind), .src_id(src_id), .rpt_valid(m_rvalid), .rpt_ready(rpt_ready),
        .rpt_src(m_rsrc), .rpt_kind(m_rkind), .rpt_id(m_rid), .final_req(final_req),
        .final_done(m_done), .fail_cnt(m_fail), .cover_cnt(m_cover)
    );

    assert_event_arbiter #(.N_SRC(N), .ID_W(SIDW), .CNT_W(SCW)) dut_s (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(s_ready),
        .src_kind(src_kind), .src_id(s_src_id), .rpt_valid(s_rvalid), .rpt_ready(rpt_ready),
        .rpt_src(s_rsrc), .rpt_kind(s_rkind), .rpt_id(s_rid), .final_req(final_req),
        .final_done(s_done), .fail_cnt(s_fail), .cover_cnt(s_cover)
    );

    // Reference model: phase 0 run, 1 drain, 2 summary, 3 done; counts kept unsaturated.
    int e_phase, e_ptr, e_fail, e_cover, e_src, e_kind, e_id;
    bit e_hold, e_sum, e_done;
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic int exp_grant();
        int i;
        if (e_phase != 0 || (e_hold && !rpt_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            i = (e_ptr + k) % N;
            if (src_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        e_phase = 0; e_ptr = 0; e_fail = 0; e_cover = 0;
        e_hold = 1'b0; e_sum = 1'b0; e_done = 1'b0;
        e_src = 0; e_kind = 0; e_id = 0;
    endtask

    task automatic check_outputs();
        int mid, sid;
        mid = e_sum ? clampv(clampv(e_fail, 65535), 255) : e_id;
        sid = e_sum ? clampv(clampv(e_fail, 15), 7) : (e_id & 7);
        check_val("rpt_valid", 32'(m_rvalid), 32'(e_hold));
        check_val("s_rpt_valid", 32'(s_rvalid), 32'(e_hold));
        if (e_hold) begin
            check_val("rpt_src", 32'(m_rsrc), 32'(e_src));
            check_val("rpt_kind", 32'(m_rkind), 32'(e_kind));
            check_val("rpt_id", 32'(m_rid), 32'(mid));
            check_val("s_rpt_src", 32'(s_rsrc), 32'(e_src));
            check_val("s_rpt_id", 32'(s_rid), 32'(sid));
        end
        check_val("fail_cnt", 32'(m_fail), 32'(clampv(e_fail, 65535)));
        check_val("cover_cnt", 32'(m_cover), 32'(clampv(e_cover, 65535)));
        check_val("s_fail_cnt", 32'(s_fail), 32'(clampv(e_fail, 15)));
        check_val("s_cover_cnt", 32'(s_cover), 32'(clampv(e_cover, 15)));
        check_val("final_done", 32'(m_done), 32'(e_done));
        check_val("s_final_done", 32'(s_done), 32'(e_done));
    endtask

    // One clock: check grant before the edge, advance the model, check registers after it.
    task automatic cycle();
        int  g, k;
        bit  old_hold;
        #1;
        g = exp_grant();
        check_val("src_ready", 32'(m_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        check_val("s_src_ready", 32'(s_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        @(posedge clk);
        old_hold = e_hold;
        if (g >= 0) begin
            k = int'(src_kind[2*g +: 2]);
            e_hold = 1'b1; e_sum = 1'b0; e_src = g; e_kind = k;
            e_id = int'(src_id[IDW*g +: IDW]);
            if (k == 0 || k == 2) e_fail++;
            if (k == 1) e_cover++;
            e_ptr = (g + 1) % N;
        end else if (e_phase == 1 && !old_hold) begin
            e_hold = 1'b1; e_sum = 1'b1; e_src = 0; e_kind = 3;
        end else if (old_hold && rpt_ready) begin
            e_hold = 1'b0;
        end
        case (e_phase)
            0: if (final_req) e_phase = 1;
            1: if (!old_hold) e_phase = 2;
            2: if (old_hold && rpt_ready) begin e_phase = 3; e_done = 1'b1; end
            default: ;
        endcase
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_rpt_valid", 32'(m_rvalid), 32'd0);
        check_val("rst_rpt_src", 32'(m_rsrc), 32'd0);
        check_val("rst_rpt_kind", 32'(m_rkind), 32'd0);
        check_val("rst_rpt_id", 32'(m_rid), 32'd0);
        check_val("rst_fail_cnt", 32'(m_fail), 32'd0);
        check_val("rst_cover_cnt", 32'(m_cover), 32'd0);
        check_val("rst_final_done", 32'(m_done), 32'd0);
        check_val("rst_src_ready", 32'(m_ready), 32'd0);
        check_val("rst_s_rpt_valid", 32'(s_rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_src(input int i, input bit v, input int k, input int id);
        src_valid[i]          = v;
        src_kind[2*i +: 2]    = 2'(k);
        src_id[IDW*i +: IDW]  = 8'(id);
    endtask

    initial begin
        rst_n = 1'b0; src_valid = '0; src_kind = '0; src_id = '0;
        rpt_ready = 1'b0; final_req = 1'b0;
        model_reset();
        #1;
        do_reset();

        // All sources valid continuously: strict rotation, one record per cycle.
        rpt_ready = 1'b1;
        for (int i = 0; i < N; i++) set_src(i, 1'b1, i, 8'h10 + i);
        repeat (12) cycle();

        // Random traffic with random back-pressure.
        repeat (400) begin
            src_valid = 4'($urandom_range(0, 15));
            src_kind  = 8'($urandom);
            src_id    = 32'($urandom);
            rpt_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Single fail held under back-pressure; other sources must wait.
        src_valid = '0;
        do_reset();
        rpt_ready = 1'b0;
        set_src(2, 1'b1, 0, 8'h5A);
        cycle();
        set_src(2, 1'b0, 0, 8'h00);
        set_src(0, 1'b1, 1, 8'h11);
        set_src(1, 1'b1, 2, 8'h22);
        repeat (3) cycle();
        rpt_ready = 1'b1;
        repeat (4) cycle();

        // Saturation: 20 covers and 20 fails, then flush to summary.
        src_valid = '0;
        do_reset();
        rpt_ready = 1'b1;
        set_src(0, 1'b1, 1, 8'hC0);
        set_src(3, 1'b1, 0, 8'hF3);
        repeat (40) cycle();
        final_req = 1'b1;
        repeat (6) cycle();
        final_req = 1'b0;
        repeat (3) cycle();

        // 3 fails, 2 covers, then final_req while source 1 is still valid.
        src_valid = '0; final_req = 1'b0;
        do_reset();
        rpt_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            set_src(1, 1'b1, (n < 3) ? 0 : 1, 8'h40 + n);
            cycle();
        end
        set_src(1, 1'b1, 3, 8'h77);
        final_req = 1'b1;
        rpt_ready = 1'b0;
        cycle();
        repeat (2) cycle();
        rpt_ready = 1'b1;
        repeat (3) cycle();
        rpt_ready = 1'b0;
        cycle();
        rpt_ready = 1'b1;
        repeat (3) cycle();
        final_req = 1'b0;
        repeat (3) cycle();

        // Reset while a record is held in DRAIN, then resume from source 0.
        src_valid = '0; final_req = 1'b0;
        do_reset();
        rpt_ready = 1'b0;
        set_src(0, 1'b1, 0, 8'h99);
        cycle();
        final_req = 1'b1;
        repeat (2) cycle();
        do_reset();
        final_req = 1'b0;
        rpt_ready = 1'b1;
        set_src(0, 1'b1, 1, 8'h3C);
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
